// File: rtl/cpu5_pkg.sv
// Shared definitions for the 5-bit datapath: widths, ALU opcodes and sequencer states.
package cpu5_pkg;

  localparam int W    = 5;
  localparam int NREG = 4;
  localparam int AW   = $clog2(NREG);
  localparam int OPW  = 3;

  localparam logic [OPW-1:0] OP_ADD = 3'b000;
  localparam logic [OPW-1:0] OP_SUB = 3'b001;
  localparam logic [OPW-1:0] OP_AND = 3'b010;
  localparam logic [OPW-1:0] OP_OR  = 3'b011;
  localparam logic [OPW-1:0] OP_XOR = 3'b100;
  localparam logic [OPW-1:0] OP_ROL = 3'b101;
  localparam logic [OPW-1:0] OP_ROR = 3'b110;
  localparam logic [OPW-1:0] OP_LD  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  // Load/move bypasses the ALU and writes operand B unchanged.
  function automatic logic [W-1:0] wb_select(input logic [OPW-1:0] op,
                                             input logic [W-1:0]   b,
                                             input logic [W-1:0]   r);
    return (op == OP_LD) ? b : r;
  endfunction

endpackage

// File: rtl/cpu5_regfile.sv
// Direct-addressed register file: two combinational read ports, a debug read port,
// and one synchronous write port.
module cpu5_regfile
  import cpu5_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra_addr,
  output logic [W-1:0]  ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [W-1:0]  rb_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd
);

  logic [W-1:0] regs_q [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[wa] <= wd;
    end
  end

  assign ra_data  = regs_q[ra_addr];
  assign rb_data  = regs_q[rb_addr];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_operand_sequencer.sv
// Three-cycle operand sequencer in front of the 5-bit ALU: accept/read, execute, write back.
module alu_operand_sequencer
  import cpu5_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_op,
  input  logic [AW-1:0]  in_rd,
  input  logic [AW-1:0]  in_rs,
  input  logic [AW-1:0]  in_rt,
  input  logic           in_use_imm,
  input  logic [W-1:0]   in_imm,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [W-1:0]   alu_r,
  output logic           wb_valid,
  output logic [AW-1:0]  wb_rd,
  output logic [W-1:0]   wb_data,
  output logic           zero_flag,
  input  logic [AW-1:0]  dbg_addr,
  output logic [W-1:0]   dbg_data
);

  state_t        state_q, state_d;
  logic [AW-1:0] rd_p0;
  logic [W-1:0]  data_p1;
  logic          zero_p2;
  logic [W-1:0]  rs_data, rt_data;

  cpu5_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .ra_addr  (in_rs),
    .ra_data  (rs_data),
    .rb_addr  (in_rt),
    .rb_data  (rt_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (state_q == WB),
    .wa       (rd_p0),
    .wd       (data_p1)
  );

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    wb_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = EXEC;
      end
      EXEC: state_d = WB;
      WB: begin
        wb_valid = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      rd_p0   <= '0;
      data_p1 <= '0;
      zero_p2 <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        // Accept: operands are frozen here and held toward the ALU until the next accept.
        IDLE: begin
          if (in_valid) begin
            alu_a  <= rs_data;
            alu_b  <= in_use_imm ? in_imm : rt_data;
            alu_op <= in_op;
            rd_p0  <= in_rd;
          end
        end
        // Execute: capture the ALU result (or operand B for load/move).
        EXEC: data_p1 <= wb_select(alu_op, alu_b, alu_r);
        // Write back: register file write happens on this same edge.
        WB: zero_p2 <= (data_p1 == '0);
        default: ;
      endcase
    end
  end

  assign wb_rd     = rd_p0;
  assign wb_data   = data_p1;
  assign zero_flag = zero_p2;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer with a behavioural 5-bit ALU on the operand bus.
module tb_alu_operand_sequencer;
  import cpu5_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_op;
  logic [AW-1:0]  in_rd, in_rs, in_rt;
  logic           in_use_imm;
  logic [W-1:0]   in_imm;
  logic [W-1:0]   alu_a, alu_b, alu_r;
  logic [OPW-1:0] alu_op;
  logic           wb_valid;
  logic [AW-1:0]  wb_rd;
  logic [W-1:0]   wb_data;
  logic           zero_flag;
  logic [AW-1:0]  dbg_addr;
  logic [W-1:0]   dbg_data;

  typedef struct {
    logic [AW-1:0] rd;
    logic [W-1:0]  data;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_operand_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .zero_flag(zero_flag),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  function automatic logic [W-1:0] rotl(input logic [W-1:0] a, input logic [1:0] s);
    logic [2*W-1:0] t;
    t = {a, a} << s;
    return t[2*W-1:W];
  endfunction

  function automatic logic [W-1:0] rotr(input logic [W-1:0] a, input logic [1:0] s);
    logic [2*W-1:0] t;
    t = {a, a} >> s;
    return t[W-1:0];
  endfunction

  // Reference ALU: rotate unit only looks at B[1:0].
  always_comb begin
    alu_r = '0;
    case (alu_op)
      OP_ADD: alu_r = alu_a + alu_b;
      OP_SUB: alu_r = alu_a - alu_b;
      OP_AND: alu_r = alu_a & alu_b;
      OP_OR:  alu_r = alu_a | alu_b;
      OP_XOR: alu_r = alu_a ^ alu_b;
      OP_ROL: alu_r = rotl(alu_a, alu_b[1:0]);
      OP_ROR: alu_r = rotr(alu_a, alu_b[1:0]);
      default: alu_r = '0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write-back pulse must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (wb_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_wb", {27'd0, wb_rd, wb_data}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("wb_rd", wb_rd, e.rd);
          chk("wb_data", wb_data, e.data);
          @(negedge clk);
          chk("zero_flag", zero_flag, (e.data == 0));
        end
      end
    end
  end

  task automatic issue(input logic [OPW-1:0] op, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic ui, input logic [W-1:0] imm,
                       input logic [W-1:0] exp, input bit push);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_use_imm = ui; in_imm = imm;
    in_valid = 1'b1;
    if (push) begin
      e.rd = rd; e.data = exp;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Issue and wait until the sequencer is back in IDLE after the write.
  task automatic run(input logic [OPW-1:0] op, input logic [AW-1:0] rd,
                     input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                     input logic ui, input logic [W-1:0] imm, input logic [W-1:0] exp);
    issue(op, rd, rs, rt, ui, imm, exp, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs = '0; in_rt = '0;
    in_use_imm = 1'b0; in_imm = '0; dbg_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_zero", zero_flag, 0);
    chk("rst_operands", {alu_a, alu_b, alu_op}, 0);
    chk("rst_wb_fields", {wb_rd, wb_data}, 0);
    for (int i = 0; i < NREG; i++) begin
      dbg_addr = AW'(i);
      #1 chk("rst_reg", dbg_data, 0);
    end

    // LD r1 = 10011; ready drops for exactly two cycles
    issue(OP_LD, 2'd1, 2'd0, 2'd0, 1'b1, 5'b10011, 5'b10011, 1'b1);
    @(negedge clk); chk("busy_exec", in_ready, 0);
    @(negedge clk); chk("busy_wb", in_ready, 0);
    @(negedge clk); chk("ready_back", in_ready, 1);

    // ROL r2 = r1 rol 2
    issue(OP_ROL, 2'd2, 2'd1, 2'd0, 1'b1, 5'd2, 5'b01110, 1'b1);
    @(negedge clk);
    chk("exec_alu_a", alu_a, 5'b10011);
    chk("exec_alu_b", alu_b, 5'b00010);
    chk("exec_alu_op", alu_op, OP_ROL);
    @(negedge clk); @(negedge clk);
    dbg_addr = 2'd2;
    #1 chk("dbg_r2", dbg_data, 5'b01110);

    // ROL by 5 behaves as by 1; rs == rd uses the old value
    run(OP_ROL, 2'd1, 2'd1, 2'd0, 1'b1, 5'd5, 5'b00111);
    dbg_addr = 2'd1;
    #1 chk("dbg_r1_alias", dbg_data, 5'b00111);

    run(OP_LD, 2'd3, 2'd0, 2'd0, 1'b1, 5'd0, 5'd0);
    run(OP_LD, 2'd3, 2'd0, 2'd0, 1'b1, 5'd6, 5'd6);
    run(OP_ADD, 2'd0, 2'd1, 2'd2, 1'b0, 5'd0, 5'd21);   // 7 + 14
    run(OP_SUB, 2'd2, 2'd3, 2'd1, 1'b0, 5'd0, 5'd31);   // 6 - 7 wraps
    run(OP_XOR, 2'd1, 2'd0, 2'd0, 1'b1, 5'd21, 5'd0);
    run(OP_LD, 2'd3, 2'd0, 2'd2, 1'b0, 5'd0, 5'd31);    // move r2 -> r3
    run(OP_AND, 2'd0, 2'd3, 2'd0, 1'b1, 5'd10, 5'd10);
    run(OP_ROR, 2'd1, 2'd0, 2'd0, 1'b1, 5'd1, 5'd5);    // 01010 ror 1

    // in_valid held high with new fields every cycle: only every third is taken
    for (int c = 0; c < 9; c++) begin
      exp_t e;
      @(negedge clk);
      chk("stream_ready", in_ready, (c % 3 == 0));
      in_valid = 1'b1; in_op = OP_LD; in_use_imm = 1'b1;
      in_rd = AW'(c % 4); in_rs = '0; in_rt = '0; in_imm = W'(8 + c);
      if (c % 3 == 0) begin
        e.rd = AW'(c % 4); e.data = W'(8 + c);
        sb.push_back(e);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    dbg_addr = 2'd1;
    #1 chk("stream_r1_unlatched", dbg_data, 5'd5);

    // Reset while an LD r0 = 31 is in EXEC
    issue(OP_LD, 2'd0, 2'd0, 2'd0, 1'b1, 5'd31, 5'd31, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_wb_valid", wb_valid, 0);
    chk("abort_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_ready_after", in_ready, 1);
    dbg_addr = 2'd0;
    #1 chk("abort_r0", dbg_data, 0);

    run(OP_LD, 2'd2, 2'd0, 2'd0, 1'b1, 5'd4, 5'd4);
    run(OP_ADD, 2'd2, 2'd2, 2'd2, 1'b0, 5'd0, 5'd8);
    dbg_addr = 2'd2;
    #1 chk("dbg_r2_final", dbg_data, 5'd8);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
